// File: rtl/max_pool_if.sv
// DRAM-side bus of the max-pool stage: single outstanding read, fire-and-forget write.
interface max_pool_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 18
);
  logic                  dram_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic                  dram_en_wr;
  logic                  dram_en_rd;

  modport master (
    input  dram_valid, data_in,
    output data_out, addr_in, addr_out, dram_en_wr, dram_en_rd
  );

  modport slave (
    output dram_valid, data_in,
    input  data_out, addr_in, addr_out, dram_en_wr, dram_en_rd
  );
endinterface

// File: rtl/max_pool.sv
// Optional ReLU + 2x2/stride-2 max pooling over a channel-major feature map in DRAM.
module max_pool #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 18,
  parameter int unsigned           IN_WIDTH   = 28,
  parameter int unsigned           IN_HEIGHT  = 28,
  parameter int unsigned           NUM_CHNL   = 6,
  parameter logic [ADDR_WIDTH-1:0] SRC_BASE   = ADDR_WIDTH'(0),
  parameter logic [ADDR_WIDTH-1:0] DST_BASE   = ADDR_WIDTH'(40000),
  parameter bit                    RELU_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       srstn,
  input  logic       enable,
  output logic       done,
  max_pool_if.master bus
);

  localparam int unsigned OW  = IN_WIDTH / 2;
  localparam int unsigned OH  = IN_HEIGHT / 2;
  localparam int unsigned OXW = (OW > 1) ? $clog2(OW) : 1;
  localparam int unsigned OYW = (OH > 1) ? $clog2(OH) : 1;
  localparam int unsigned CHW = (NUM_CHNL > 1) ? $clog2(NUM_CHNL) : 1;

  localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(IN_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ROW2_STEP = ADDR_WIDTH'(2 * IN_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] CH_STEP   = ADDR_WIDTH'(IN_WIDTH * IN_HEIGHT);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} state_t;

  state_t                state;
  logic [CHW-1:0]        ch;
  logic [OYW-1:0]        oy;
  logic [OXW-1:0]        ox;
  logic [1:0]            k;
  logic [DATA_WIDTH-1:0] mx;
  logic [ADDR_WIDTH-1:0] ch_ptr, row_ptr, win_ptr, dst_ptr;

  logic                  last_ox, last_oy, last_ch;
  logic [ADDR_WIDTH-1:0] nxt_ch_ptr, nxt_row_ptr, nxt_win_ptr;
  logic [DATA_WIDTH-1:0] max_c, pooled_c;

  // Offset of window element kk from the window's top-left word.
  function automatic logic [ADDR_WIDTH-1:0] win_ofs(input logic [1:0] kk);
    return (kk[1] ? ROW_STEP : '0) + ADDR_WIDTH'(kk[0]);
  endfunction

  // Pointer advance to the next window; odd trailing columns/rows are skipped by re-basing from row/channel pointers.
  always_comb begin
    last_ox     = (ox == OXW'(OW - 1));
    last_oy     = (oy == OYW'(OH - 1));
    last_ch     = (ch == CHW'(NUM_CHNL - 1));
    nxt_ch_ptr  = ch_ptr;
    nxt_row_ptr = row_ptr;
    nxt_win_ptr = win_ptr + ADDR_WIDTH'(2);
    if (last_ox) begin
      if (last_oy) begin
        nxt_ch_ptr  = ch_ptr + CH_STEP;
        nxt_row_ptr = nxt_ch_ptr;
      end else begin
        nxt_row_ptr = row_ptr + ROW2_STEP;
      end
      nxt_win_ptr = nxt_row_ptr;
    end
  end

  always_comb begin
    max_c    = ((k == 2'd0) || ($signed(bus.data_in) > $signed(mx))) ? bus.data_in : mx;
    pooled_c = (RELU_EN && max_c[DATA_WIDTH-1]) ? '0 : max_c;
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state          <= IDLE;
      ch             <= '0;
      oy             <= '0;
      ox             <= '0;
      k              <= '0;
      mx             <= '0;
      ch_ptr         <= '0;
      row_ptr        <= '0;
      win_ptr        <= '0;
      dst_ptr        <= '0;
      done           <= 1'b0;
      bus.data_out   <= '0;
      bus.addr_in    <= '0;
      bus.addr_out   <= '0;
      bus.dram_en_rd <= 1'b0;
      bus.dram_en_wr <= 1'b0;
    end else begin
      bus.dram_en_rd <= 1'b0;
      bus.dram_en_wr <= 1'b0;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (enable) begin
            state          <= RD;
            ch             <= '0;
            oy             <= '0;
            ox             <= '0;
            k              <= '0;
            ch_ptr         <= SRC_BASE;
            row_ptr        <= SRC_BASE;
            win_ptr        <= SRC_BASE;
            dst_ptr        <= DST_BASE;
            bus.addr_in    <= SRC_BASE;
            bus.dram_en_rd <= 1'b1;
          end
        end
        RD: state <= enable ? WAIT : IDLE;
        WAIT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (bus.dram_valid) begin
            mx <= max_c;
            if (k == 2'd3) begin
              state          <= WR;
              bus.dram_en_wr <= 1'b1;
              bus.addr_out   <= dst_ptr;
              bus.data_out   <= pooled_c;
            end else begin
              k              <= k + 2'd1;
              state          <= RD;
              bus.dram_en_rd <= 1'b1;
              bus.addr_in    <= win_ptr + win_ofs(k + 2'd1);
            end
          end
        end
        WR: begin
          if (!enable) begin
            state <= IDLE;
          end else begin
            k       <= '0;
            ox      <= last_ox ? '0 : ox + OXW'(1);
            if (last_ox) oy <= last_oy ? '0 : oy + OYW'(1);
            if (last_ox && last_oy) ch <= ch + CHW'(1);
            ch_ptr  <= nxt_ch_ptr;
            row_ptr <= nxt_row_ptr;
            win_ptr <= nxt_win_ptr;
            dst_ptr <= dst_ptr + ADDR_WIDTH'(1);
            if (last_ox && last_oy && last_ch) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state          <= RD;
              bus.dram_en_rd <= 1'b1;
              bus.addr_in    <= nxt_win_ptr;
            end
          end
        end
        DONE: begin
          if (!enable) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
